// File: rtl/router_input_port_pkg.sv
// Shared flit definitions for the NIC-to-router link: flit-type encodings,
// field offsets, VC/credit sizing and a constant clog2 helper, so both ends
// of the link decode flits identically.
package router_input_port_pkg;

    localparam int FLIT_WIDTH = 64;
    localparam int N_OF_VC    = 2;
    localparam int N_OF_VN    = 2;
    localparam int MAX_CREDIT = 4;

    // Field offsets counted down from the flit MSB:
    // type occupies [W-1:W-2], VC id starts at bit W-3 and grows downward.
    localparam int TYPE_MSB_OFS = 1;
    localparam int VC_MSB_OFS   = 3;

    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_TAIL      = 2'b01,
        FLIT_HEAD      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Per-VC receive state, only built when protocol checking is enabled.
    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_OPEN = 1'b1
    } rx_state_e;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A tail or head-tail flit releases its VC when it leaves the buffer.
    function automatic logic is_release(input flit_type_e t);
        return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO. DEPTH need not be a power of two: the
// pointers wrap explicitly at DEPTH-1. The owner guarantees that pop is only
// raised when non-empty and push only when not full or popping the same cycle.
module vc_fifo #(
    parameter int WIDTH = router_input_port_pkg::FLIT_WIDTH,
    parameter int DEPTH = router_input_port_pkg::MAX_CREDIT,
    localparam int PTR_W = (router_input_port_pkg::clog2(DEPTH) > 0) ?
                           router_input_port_pkg::clog2(DEPTH) : 1,
    localparam int CNT_W = router_input_port_pkg::clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (cnt == CNT_W'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_data = mem[rd_ptr];

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; push+pop together leaves cnt unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/router_input_port.sv
// Router input port: receives credit-flow-controlled flits from the NIC into
// one FIFO per VC, offers one flit per cycle to the crossbar via round-robin
// valid/ready arbitration, and returns credit/free pulses to the NIC.
// Optional protocol checking of per-VC flit sequences: ROUTER_IN_CHECK_EN.
//
// Handshake: out_valid_o/out_flit_o/out_vc_o depend only on registered state;
// once out_valid_o is high it stays high with the same flit and VC until a
// cycle with out_ready_i high, where the transfer happens on that clock edge.
module router_input_port #(
    parameter int FLIT_WIDTH   = router_input_port_pkg::FLIT_WIDTH,
    parameter int N_TOT_OF_VC  = router_input_port_pkg::N_OF_VC * router_input_port_pkg::N_OF_VN,
    parameter int BUFFER_DEPTH = router_input_port_pkg::MAX_CREDIT,
    parameter int N_BITS_VC    = (router_input_port_pkg::clog2(N_TOT_OF_VC) > 0) ?
                                 router_input_port_pkg::clog2(N_TOT_OF_VC) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] credit_signal_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    output logic [FLIT_WIDTH-1:0]  out_flit_o,
    output logic [N_BITS_VC-1:0]   out_vc_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   err_overflow_o,
    output logic                   err_protocol_o
);

    import router_input_port_pkg::*;

    localparam int CNT_W = clog2(BUFFER_DEPTH + 1);

    logic [N_BITS_VC-1:0]   in_vc;
    logic [N_TOT_OF_VC-1:0] push_vec;
    logic [N_TOT_OF_VC-1:0] pop_vec;
    logic [N_TOT_OF_VC-1:0] full_w;
    logic [N_TOT_OF_VC-1:0] empty_w;
    logic [CNT_W-1:0]       count_w [N_TOT_OF_VC];
    logic [FLIT_WIDTH-1:0]  head_w  [N_TOT_OF_VC];

    logic                 space_ok;
    logic                 proto_ok;
    logic                 overflow_evt;
    logic                 protocol_evt;
    logic                 xfer;
    logic [N_BITS_VC-1:0] grant_vc;
    logic                 grant_found;
    logic [N_BITS_VC-1:0] rr_ptr;
    logic                 lock_q;
    logic [N_BITS_VC-1:0] lock_vc;
    logic                 out_release;

    assign in_vc = in_link_i[FLIT_WIDTH-VC_MSB_OFS -: N_BITS_VC];

`ifdef ROUTER_IN_CHECK_EN
    flit_type_e in_type;
    rx_state_e  rx_state_q [N_TOT_OF_VC];
    rx_state_e  rx_state_d [N_TOT_OF_VC];

    assign in_type = flit_type_e'(in_link_i[FLIT_WIDTH-1 -: 2]);

    // Heads open an IDLE VC; body/tail must follow inside an OPEN VC.
    always_comb begin
        proto_ok = 1'b1;
        if (rx_state_q[in_vc] == RX_OPEN) begin
            proto_ok = (in_type == FLIT_BODY) || (in_type == FLIT_TAIL);
        end else begin
            proto_ok = (in_type == FLIT_HEAD) || (in_type == FLIT_HEAD_TAIL);
        end
    end

    // Receive state register per VC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TOT_OF_VC; i++) rx_state_q[i] <= RX_IDLE;
        end else begin
            for (int i = 0; i < N_TOT_OF_VC; i++) rx_state_q[i] <= rx_state_d[i];
        end
    end

    // Receive state transitions, advanced only by accepted flits.
    always_comb begin
        for (int i = 0; i < N_TOT_OF_VC; i++) rx_state_d[i] = rx_state_q[i];
        for (int i = 0; i < N_TOT_OF_VC; i++) begin
            if (push_vec[i]) begin
                case (in_type)
                    FLIT_HEAD: rx_state_d[i] = RX_OPEN;
                    FLIT_TAIL: rx_state_d[i] = RX_IDLE;
                    default:   rx_state_d[i] = rx_state_q[i];
                endcase
            end
        end
    end
`else
    assign proto_ok = 1'b1;
`endif

    // Intake: accept into FIFO[vc] if there is room (a same-cycle pop makes room).
    always_comb begin
        push_vec     = '0;
        space_ok     = !full_w[in_vc] || pop_vec[in_vc];
        overflow_evt = is_valid_i && (count_w[in_vc] == CNT_W'(BUFFER_DEPTH)) && !pop_vec[in_vc];
        protocol_evt = is_valid_i && !proto_ok;
        if (is_valid_i && space_ok && proto_ok) push_vec[in_vc] = 1'b1;
    end

    // Round-robin search from rr_ptr, overridden by the held grant while stalled.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_vc    = rr_ptr;
        for (int i = 0; i < N_TOT_OF_VC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_TOT_OF_VC) idx = idx - N_TOT_OF_VC;
            if (!grant_found && !empty_w[idx]) begin
                grant_found = 1'b1;
                grant_vc    = N_BITS_VC'(idx);
            end
        end
        if (lock_q) begin
            grant_found = 1'b1;
            grant_vc    = lock_vc;
        end
    end

    // Crossbar offer and pop decode.
    always_comb begin
        out_valid_o = grant_found;
        out_vc_o    = grant_found ? grant_vc : '0;
        out_flit_o  = grant_found ? head_w[grant_vc] : '0;
        xfer        = out_valid_o && out_ready_i;
        pop_vec     = '0;
        if (xfer) pop_vec[grant_vc] = 1'b1;
        out_release = is_release(flit_type_e'(out_flit_o[FLIT_WIDTH-1 -: 2]));
    end

    // Grant lock and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= 1'b0;
            lock_vc <= '0;
            rr_ptr  <= '0;
        end else begin
            lock_q  <= out_valid_o && !out_ready_i;
            lock_vc <= grant_vc;
            if (xfer) begin
                rr_ptr <= (grant_vc == N_BITS_VC'(N_TOT_OF_VC - 1)) ? '0 : grant_vc + 1'b1;
            end
        end
    end

    // Credit and free pulses, one cycle after the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_signal_o <= '0;
            free_signal_o   <= '0;
        end else begin
            credit_signal_o <= pop_vec;
            free_signal_o   <= pop_vec & {N_TOT_OF_VC{out_release}};
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow_o <= 1'b0;
        end else if (overflow_evt) begin
            err_overflow_o <= 1'b1;
        end
    end

`ifdef ROUTER_IN_CHECK_EN
    // Protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_protocol_o <= 1'b0;
        end else if (protocol_evt) begin
            err_protocol_o <= 1'b1;
        end
    end
`else
    assign err_protocol_o = 1'b0;
    logic unused_protocol;
    assign unused_protocol = protocol_evt;
`endif

    for (genvar g = 0; g < N_TOT_OF_VC; g++) begin : g_vc
        vc_fifo #(
            .WIDTH(FLIT_WIDTH),
            .DEPTH(BUFFER_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push_vec[g]),
            .pop      (pop_vec[g]),
            .push_data(in_link_i),
            .full     (full_w[g]),
            .empty    (empty_w[g]),
            .count    (count_w[g]),
            .head_data(head_w[g])
        );
    end

endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port: single packet, VC fill/overflow,
// round-robin fairness, stalled grant, protocol check and mid-packet reset.
module tb_router_input_port;

    localparam int FW  = 64;
    localparam int NVC = 4;
    localparam int NB  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [FW-1:0]  in_link_i = '0;
    logic           is_valid_i = 1'b0;
    logic [NVC-1:0] credit_signal_o;
    logic [NVC-1:0] free_signal_o;
    logic [FW-1:0]  out_flit_o;
    logic [NB-1:0]  out_vc_o;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic           err_overflow_o;
    logic           err_protocol_o;

    int vecs = 0;
    int errs = 0;

    router_input_port dut (
        .clk            (clk),
        .rst            (rst),
        .in_link_i      (in_link_i),
        .is_valid_i     (is_valid_i),
        .credit_signal_o(credit_signal_o),
        .free_signal_o  (free_signal_o),
        .out_flit_o     (out_flit_o),
        .out_vc_o       (out_vc_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .err_overflow_o (err_overflow_o),
        .err_protocol_o (err_protocol_o)
    );

    // Clock and time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] vc, input logic [31:0] pay);
        logic [FW-1:0] f;
        f = '0;
        f[63:62] = t;
        f[61:60] = vc;
        f[31:0]  = pay;
        return f;
    endfunction

    // Driver: present one flit for exactly one clock edge.
    task automatic send(input logic [FW-1:0] f);
        in_link_i  = f;
        is_valid_i = 1'b1;
        step();
        is_valid_i = 1'b0;
        in_link_i  = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  out_valid_o, 0);
        check({tag, "_flit"},   out_flit_o, 0);
        check({tag, "_vc"},     out_vc_o, 0);
        check({tag, "_credit"}, credit_signal_o, 0);
        check({tag, "_free"},   free_signal_o, 0);
        check({tag, "_ovf"},    err_overflow_o, 0);
        check({tag, "_perr"},   err_protocol_o, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero(tag);
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [FW-1:0] last_flit;
        logic [FW-1:0] f2;
        logic [1:0]    fair_vc  [6];
        logic [31:0]   fair_pay [6];
        int            cred_cnt;
        int            free_cnt;

        // Reset
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Single packet on VC2, ready high
        out_ready_i = 1'b1;
        send(mk(2'b10, 2, 32'h21));
        check("pkt_h_valid", out_valid_o, 1);
        check("pkt_h_vc", out_vc_o, 2);
        check("pkt_h_flit", out_flit_o, mk(2'b10, 2, 32'h21));
        check("pkt_h_credit", credit_signal_o, 4'b0000);
        send(mk(2'b00, 2, 32'h22));
        check("pkt_b_flit", out_flit_o, mk(2'b00, 2, 32'h22));
        check("pkt_b_credit", credit_signal_o, 4'b0100);
        check("pkt_b_free", free_signal_o, 4'b0000);
        send(mk(2'b01, 2, 32'h23));
        check("pkt_t_flit", out_flit_o, mk(2'b01, 2, 32'h23));
        check("pkt_t_credit", credit_signal_o, 4'b0100);
        check("pkt_t_free", free_signal_o, 4'b0000);
        step();
        check("pkt_end_valid", out_valid_o, 0);
        check("pkt_end_credit", credit_signal_o, 4'b0100);
        check("pkt_end_free", free_signal_o, 4'b0100);
        step();
        check("pkt_idle_credit", credit_signal_o, 4'b0000);
        check("pkt_idle_free", free_signal_o, 4'b0000);

        // Fill VC0 with ready low, then overflow it
        out_ready_i = 1'b0;
        send(mk(2'b10, 0, 32'h10));
        send(mk(2'b00, 0, 32'h11));
        send(mk(2'b00, 0, 32'h12));
        send(mk(2'b01, 0, 32'h13));
        check("fill_ovf_before", err_overflow_o, 0);
        check("fill_head_flit", out_flit_o, mk(2'b10, 0, 32'h10));
        send(mk(2'b11, 0, 32'h14));
        check("fill_ovf_set", err_overflow_o, 1);
        check("fill_vc", out_vc_o, 0);
        check("fill_stall_credit", credit_signal_o, 4'b0000);
        out_ready_i = 1'b1;
        cred_cnt  = 0;
        free_cnt  = 0;
        last_flit = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_o) last_flit = out_flit_o;
            step();
            cred_cnt += $countones(credit_signal_o);
            free_cnt += $countones(free_signal_o);
        end
        check("fill_credits", cred_cnt, 4);
        check("fill_frees", free_cnt, 1);
        check("fill_last_flit", last_flit, mk(2'b01, 0, 32'h13));
        check("fill_drained", out_valid_o, 0);
        check("fill_ovf_sticky", err_overflow_o, 1);

        // Fairness over VC0, VC1, VC3 from rr_ptr = 0
        do_reset("rst_fair");
        out_ready_i = 1'b0;
        send(mk(2'b11, 0, 32'h00));
        send(mk(2'b11, 0, 32'h01));
        send(mk(2'b11, 1, 32'h10));
        send(mk(2'b11, 1, 32'h11));
        send(mk(2'b11, 3, 32'h30));
        send(mk(2'b11, 3, 32'h31));
        fair_vc  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        fair_pay = '{32'h00, 32'h10, 32'h30, 32'h01, 32'h11, 32'h31};
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fair_valid_%0d", i), out_valid_o, 1);
            check($sformatf("fair_vc_%0d", i), out_vc_o, fair_vc[i]);
            check($sformatf("fair_flit_%0d", i), out_flit_o, mk(2'b11, fair_vc[i], fair_pay[i]));
            step();
        end
        check("fair_done", out_valid_o, 0);
        check("fair_last_credit", credit_signal_o, 4'b1000);

        // Stall: VC2 arrives first and keeps the grant while VC1 waits
        out_ready_i = 1'b0;
        step();
`ifdef ROUTER_IN_CHECK_EN
        f2 = mk(2'b11, 2, 32'h42);
`else
        f2 = mk(2'b00, 2, 32'h42);
`endif
        send(f2);
        send(mk(2'b10, 1, 32'h41));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_vc_%0d", i), out_vc_o, 2);
            check($sformatf("stall_flit_%0d", i), out_flit_o, f2);
            check($sformatf("stall_credit_%0d", i), credit_signal_o, 4'b0000);
            step();
        end
        out_ready_i = 1'b1;
        step();
        check("stall_rel_credit", credit_signal_o, 4'b0100);
        check("stall_next_vc", out_vc_o, 1);
        check("stall_next_flit", out_flit_o, mk(2'b10, 1, 32'h41));
        step();
        check("stall_vc1_credit", credit_signal_o, 4'b0010);
        check("stall_empty", out_valid_o, 0);

        // Protocol check: body flit to IDLE VC1
        do_reset("rst_proto");
        out_ready_i = 1'b1;
        send(mk(2'b00, 1, 32'h51));
`ifdef ROUTER_IN_CHECK_EN
        check("proto_dropped", out_valid_o, 0);
        check("proto_err", err_protocol_o, 1);
        step();
        check("proto_no_credit", credit_signal_o, 4'b0000);
`else
        check("proto_valid", out_valid_o, 1);
        check("proto_flit", out_flit_o, mk(2'b00, 1, 32'h51));
        step();
        check("proto_credit", credit_signal_o, 4'b0010);
        check("proto_no_err", err_protocol_o, 0);
`endif

        // Reset mid-packet on VC0
        out_ready_i = 1'b0;
        step();
        send(mk(2'b10, 0, 32'h61));
        send(mk(2'b00, 0, 32'h62));
        check("mid_valid", out_valid_o, 1);
        check("mid_flit", out_flit_o, mk(2'b10, 0, 32'h61));
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        step();
        rst = 1'b0;
        step();
        check("mid_after_valid", out_valid_o, 0);
        check("mid_after_credit", credit_signal_o, 4'b0000);
        out_ready_i = 1'b1;
        send(mk(2'b11, 0, 32'h63));
        check("mid_ht_valid", out_valid_o, 1);
        check("mid_ht_flit", out_flit_o, mk(2'b11, 0, 32'h63));
        step();
        check("mid_ht_credit", credit_signal_o, 4'b0001);
        check("mid_ht_free", free_signal_o, 4'b0001);
        step();
        check("mid_ht_quiet", credit_signal_o, 4'b0000);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
